// File: rtl/audio_dac_serializer.sv
// WM8731 DAC transmit path: stereo-pair FIFO feeding a left-justified serialiser
// that is timed by the codec-mastered BCLK/LRCK, all in the CLOCK_50 domain.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         writedata_left,
  input  logic [DATA_WIDTH-1:0]         writedata_right,
  output logic                          write_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  logic [2:0]              r_bclk_sync;
  logic [2:0]              r_lrck_sync;
  logic                    r_lrck_cur, r_lrck_prev;
  logic [1:0]              r_ev;
  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wptr, r_rptr;
  logic [LW-1:0]           r_level;
  logic                    r_wready;
  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_shift, r_hold;
  logic [CW-1:0]           r_cnt;
  logic                    r_dacdat, r_underflow;

  logic                    w_bfall, w_rise, w_fall, w_empty, w_push, w_pop;
  logic [LW-1:0]           w_level_nxt;
  logic [DATA_WIDTH-1:0]   w_pop_l, w_pop_r;

  // Falling BCLK seen between sync stage 1 and the delay stage.
  assign w_bfall = r_bclk_sync[2] & ~r_bclk_sync[1];
  assign w_rise  = r_ev[1] & ~r_lrck_prev &  r_lrck_cur;
  assign w_fall  = r_ev[1] &  r_lrck_prev & ~r_lrck_cur;
  assign w_empty = (r_level == '0);
  assign w_push  = write & r_wready;
  assign w_pop   = w_rise & ~w_empty;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign {w_pop_l, w_pop_r} = r_mem[r_rptr];

  // LRCK resets high so a release mid-left-channel cannot fake a 0->1 edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '1;
      r_lrck_cur  <= 1'b1;
      r_lrck_prev <= 1'b1;
      r_ev        <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], AUD_BCLK};
      r_lrck_sync <= {r_lrck_sync[1:0], AUD_DACLRCK};
      r_ev        <= {r_ev[0], w_bfall};
      if (r_ev[0]) begin
        r_lrck_prev <= r_lrck_cur;
        r_lrck_cur  <= r_lrck_sync[2];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wptr] <= {writedata_left, writedata_right};
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_wready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_level  <= w_level_nxt;
      r_wready <= (w_level_nxt != LW'(FIFO_DEPTH));
    end
  end

  // Every transition drives the new word's MSB on the same bfall, so the
  // counter is loaded with the bits still remaining after that one.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state     <= WAIT_SYNC;
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_dacdat    <= 1'b0;
      r_underflow <= 1'b0;
    end else if (r_ev[1]) begin
      if (w_rise) begin
        r_state <= LEFT;
        r_cnt   <= CW'(DATA_WIDTH - 1);
        if (w_empty) begin
          r_dacdat    <= 1'b0;
          r_shift     <= '0;
          r_hold      <= '0;
          r_underflow <= 1'b1;
        end else begin
          r_dacdat <= w_pop_l[DATA_WIDTH-1];
          r_shift  <= w_pop_l << 1;
          r_hold   <= w_pop_r;
        end
      end else if (w_fall && r_state == LEFT) begin
        r_state  <= RIGHT;
        r_cnt    <= CW'(DATA_WIDTH - 1);
        r_dacdat <= r_hold[DATA_WIDTH-1];
        r_shift  <= r_hold << 1;
      end else if (r_state != WAIT_SYNC && r_cnt != '0) begin
        r_dacdat <= r_shift[DATA_WIDTH-1];
        r_shift  <= r_shift << 1;
        r_cnt    <= r_cnt - CW'(1);
      end else begin
        r_dacdat <= 1'b0;
      end
    end
  end

  assign write_ready = r_wready;
  assign fifo_level  = r_level;
  assign underflow   = r_underflow;
  assign AUD_DACDAT  = r_dacdat;
endmodule
